// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller.
// Contents: access codes seen on cpu_code, FSM state enum, port-owner enum.
package dmem_pkg;

    localparam logic [3:0] CODE_LW  = 4'b0000;
    localparam logic [3:0] CODE_LH  = 4'b0010;
    localparam logic [3:0] CODE_LB  = 4'b0011;
    localparam logic [3:0] CODE_LHU = 4'b0100;
    localparam logic [3:0] CODE_LBU = 4'b0101;
    localparam logic [3:0] CODE_SW  = 4'b1000;
    localparam logic [3:0] CODE_SH  = 4'b1001;
    localparam logic [3:0] CODE_SB  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter.
// Ports:
//   code      in  4   access code
//   we        in  1   1 = store
//   addr_lo   in  2   byte offset within the word
//   wdata     in  32  right-aligned store data
//   rdata     in  32  raw word from memory
//   be        out 4   byte enables (0000 for loads)
//   wdata_rep out 32  store data replicated onto every lane
//   rdata_ext out 32  selected and sign/zero-extended load data (0 for stores)
//   misalign  out 1   offset not a multiple of the access size
//   illegal   out 1   undefined code, or direction disagrees with the code
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [3:0]  code,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] shifted;
    logic [15:0] half;
    logic [7:0]  byte_sel;

    // Byte lane a sits at bit 8*a; half lane is chosen by addr_lo[1].
    assign shifted  = rdata >> {addr_lo, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half     = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
        misalign  = 1'b0;
        illegal   = 1'b0;
        case (code)
            CODE_LW: begin
                rdata_ext = rdata;
                misalign  = (addr_lo != 2'b00);
                illegal   = we;
            end
            CODE_LH: begin
                rdata_ext = {{16{half[15]}}, half};
                misalign  = addr_lo[0];
                illegal   = we;
            end
            CODE_LHU: begin
                rdata_ext = {16'h0, half};
                misalign  = addr_lo[0];
                illegal   = we;
            end
            CODE_LB: begin
                rdata_ext = {{24{byte_sel[7]}}, byte_sel};
                illegal   = we;
            end
            CODE_LBU: begin
                rdata_ext = {24'h0, byte_sel};
                illegal   = we;
            end
            CODE_SW: begin
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
                illegal  = !we;
            end
            CODE_SH: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                misalign  = addr_lo[0];
                illegal   = !we;
            end
            CODE_SB: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                illegal   = !we;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-port data-memory sequencer shared by the CPU MEM stage (port C) and
// the DMA/bridge (port D).
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   cpu_req/we/code/addr/wdata        CPU request, held until cpu_done
//   cpu_rdata/done/err, cpu_stall     CPU response; stall = req & ~done
//   dma_req/we/addr/wdata             DMA word request, held until dma_done
//   dma_rdata/done/err                DMA response
//   mem_en/be/addr/wdata              memory strobe and write data, held until mem_rdy
//   mem_rdata, mem_rdy                raw read word, completion
//   dbg_state                         current FSM state (IDLE/ACCESS/RESP)
// Handshake: a requester raises req with stable fields; the controller answers
// with a one-cycle done pulse (err/rdata valid then, held until the next done).
// req must be low in the cycle after done or it counts as a new request.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int CPU_BURST = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_code,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic        dma_err,
    output logic        mem_en,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy,
    output logic [1:0]  dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(CPU_BURST + 1);

    state_t       state;
    owner_t       owner;
    logic [3:0]   code_q;
    logic         we_q;
    logic [1:0]   alo_q;
    logic [TW-1:0] tcnt;
    logic [BW-1:0] burst;

    logic        pick_d;
    logic [3:0]  c_code;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  f_code;
    logic        f_we;
    logic [1:0]  f_alo;
    logic [3:0]  f_be;
    logic [31:0] f_wdata;
    logic [31:0] f_rdata;
    logic        f_misalign;
    logic        f_illegal;

    // CPU has priority until it has taken CPU_BURST grants back-to-back while DMA waited.
    assign pick_d  = dma_req && (!cpu_req || burst == BW'(CPU_BURST));
    assign c_code  = pick_d ? (dma_we ? CODE_SW : CODE_LW) : cpu_code;
    assign c_we    = pick_d ? dma_we : cpu_we;
    assign c_addr  = pick_d ? dma_addr : cpu_addr;
    assign c_wdata = pick_d ? dma_wdata : cpu_wdata;

    // One formatter serves both phases: the candidate request while IDLE (checks,
    // be, wdata) and the latched request while ACCESS (load extraction).
    assign f_code = (state == IDLE) ? c_code : code_q;
    assign f_we   = (state == IDLE) ? c_we : we_q;
    assign f_alo  = (state == IDLE) ? c_addr[1:0] : alo_q;

    dmem_lane_fmt u_fmt (
        .code      (f_code),
        .we        (f_we),
        .addr_lo   (f_alo),
        .wdata     (c_wdata),
        .rdata     (mem_rdata),
        .be        (f_be),
        .wdata_rep (f_wdata),
        .rdata_ext (f_rdata),
        .misalign  (f_misalign),
        .illegal   (f_illegal)
    );

    assign cpu_stall = cpu_req & ~cpu_done;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= OWN_C;
            code_q    <= 4'h0;
            we_q      <= 1'b0;
            alo_q     <= 2'b00;
            tcnt      <= '0;
            burst     <= '0;
            mem_en    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= 32'h0;
            dma_done  <= 1'b0;
            dma_err   <= 1'b0;
            dma_rdata <= 32'h0;
        end else begin
            cpu_done <= 1'b0;
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        owner  <= pick_d ? OWN_D : OWN_C;
                        code_q <= c_code;
                        we_q   <= c_we;
                        alo_q  <= c_addr[1:0];
                        if (pick_d || !dma_req) begin
                            burst <= '0;
                        end else if (burst != BW'(CPU_BURST)) begin
                            burst <= burst + BW'(1);
                        end
                        if (f_misalign || f_illegal) begin
                            // Rejected before touching memory.
                            state <= RESP;
                            if (pick_d) begin
                                dma_done  <= 1'b1;
                                dma_err   <= 1'b1;
                                dma_rdata <= 32'h0;
                            end else begin
                                cpu_done  <= 1'b1;
                                cpu_err   <= 1'b1;
                                cpu_rdata <= 32'h0;
                            end
                        end else begin
                            state     <= ACCESS;
                            mem_en    <= 1'b1;
                            mem_be    <= f_be;
                            mem_addr  <= {c_addr[31:2], 2'b00};
                            mem_wdata <= f_wdata;
                            tcnt      <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // tcnt counts completed wait cycles, so the strobe lasts TIMEOUT cycles.
                    if (mem_rdy || tcnt == TW'(TIMEOUT - 1)) begin
                        mem_en <= 1'b0;
                        state  <= RESP;
                        if (owner == OWN_D) begin
                            dma_done  <= 1'b1;
                            dma_err   <= !mem_rdy;
                            dma_rdata <= mem_rdy ? f_rdata : 32'h0;
                        end else begin
                            cpu_done  <= 1'b1;
                            cpu_err   <= !mem_rdy;
                            cpu_rdata <= mem_rdy ? f_rdata : 32'h0;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    localparam int TB_TIMEOUT = 16;
    localparam int TB_BURST   = 4;
    localparam int NEVER      = 1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_code;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_done, cpu_err, cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_done, dma_err;
    logic        mem_en;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rdy = 1'b0;
    logic [1:0]  dbg_state;

    dmem_access_ctrl #(.TIMEOUT(TB_TIMEOUT), .CPU_BURST(TB_BURST)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_code(cpu_code), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_done(dma_done), .dma_err(dma_err),
        .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model memory (spec rules) and the bench RAM the DUT writes.
    logic [31:0] ref_mem [0:63] = '{default: 32'h0};
    logic [31:0] phys    [0:63] = '{default: 32'h0};

    logic [32:0] cpu_exp_q[$];
    logic [32:0] dma_exp_q[$];
    bit          order_log[$];

    int          resp_lat = 0;
    int          acc_cyc = 0;
    int          acc_count = 0;
    int          last_en_len = 0;
    logic [3:0]  last_be = 4'h0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] last_addr = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: rdy after resp_lat wait cycles of mem_en.
    always @(negedge clk) begin
        if (mem_en) begin
            if (acc_cyc == 0) acc_count++;
            if (acc_cyc == resp_lat) begin
                mem_rdy    = 1'b1;
                mem_rdata  = phys[mem_addr[7:2]];
                last_be    = mem_be;
                last_wdata = mem_wdata;
                last_addr  = mem_addr;
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) phys[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
                mem_rdy   = 1'b0;
                mem_rdata = $urandom;
            end
            acc_cyc++;
        end else begin
            if (acc_cyc != 0) last_en_len = acc_cyc;
            acc_cyc = 0;
            mem_rdy = 1'b0;
        end
    end

    // Scoreboard monitor
    bit prev_cpu_done = 1'b0;
    bit prev_dma_done = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (cpu_done) begin
                order_log.push_back(1'b0);
                vectors++;
                if (cpu_exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL cpu_unexpected_done: got rdata 0x%0h err %0b", cpu_rdata, cpu_err);
                end else begin
                    logic [32:0] e;
                    e = cpu_exp_q.pop_front();
                    if ({cpu_err, cpu_rdata} !== e) begin
                        miscompares++;
                        $display("FAIL cpu_resp: got err %0b rdata 0x%08h expected err %0b rdata 0x%08h",
                                 cpu_err, cpu_rdata, e[32], e[31:0]);
                    end
                end
            end
            if (dma_done) begin
                order_log.push_back(1'b1);
                vectors++;
                if (dma_exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL dma_unexpected_done: got rdata 0x%0h err %0b", dma_rdata, dma_err);
                end else begin
                    logic [32:0] e;
                    e = dma_exp_q.pop_front();
                    if ({dma_err, dma_rdata} !== e) begin
                        miscompares++;
                        $display("FAIL dma_resp: got err %0b rdata 0x%08h expected err %0b rdata 0x%08h",
                                 dma_err, dma_rdata, e[32], e[31:0]);
                    end
                end
            end
            if ((cpu_done && dma_done) || (cpu_done && prev_cpu_done) || (dma_done && prev_dma_done)) begin
                vectors++;
                miscompares++;
                $display("FAIL done_pulse: cpu %0b/%0b dma %0b/%0b", cpu_done, prev_cpu_done, dma_done, prev_dma_done);
            end
        end
        prev_cpu_done = cpu_done;
        prev_dma_done = dma_done;
    end

    // Reference model: result of one access from the architectural rules.
    task automatic model_op(input bit is_d, input logic we, input logic [3:0] code,
                            input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                            output logic [32:0] exp, output bit pre_err);
        int size, off, idx;
        bit is_ld, is_st, sgn, legal;
        logic [31:0] val, mask;
        size = 4; is_ld = 0; is_st = 0; sgn = 0; legal = 1;
        if (is_d) begin
            is_st = we; is_ld = !we;
        end else begin
            case (code)
                4'h0: begin size = 4; is_ld = 1; end
                4'h2: begin size = 2; is_ld = 1; sgn = 1; end
                4'h3: begin size = 1; is_ld = 1; sgn = 1; end
                4'h4: begin size = 2; is_ld = 1; end
                4'h5: begin size = 1; is_ld = 1; end
                4'h8: begin size = 4; is_st = 1; end
                4'h9: begin size = 2; is_st = 1; end
                4'hA: begin size = 1; is_st = 1; end
                default: legal = 0;
            endcase
            if (legal && (we ? is_ld : is_st)) legal = 0;
        end
        off = int'(addr % 4);
        idx = int'(addr[7:2]);
        pre_err = !legal || (off % size) != 0;
        if (pre_err || lat >= TB_TIMEOUT) begin
            exp = {1'b1, 32'h0};
            return;
        end
        if (is_st) begin
            for (int i = 0; i < size; i++) ref_mem[idx][8*(off+i) +: 8] = wdata[8*i +: 8];
            exp = {1'b0, 32'h0};
        end else begin
            val  = ref_mem[idx] >> (8 * off);
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
            val  = val & mask;
            if (sgn && val[8*size-1]) val = val | ~mask;
            exp = {1'b0, val};
        end
    endtask

    // Driver: one request on one port, waits for its done, checks latency.
    task automatic do_op(input bit is_d, input logic we, input logic [3:0] code,
                         input logic [31:0] addr, input logic [31:0] wdata, input int lat);
        logic [32:0] exp;
        bit pre_err, seen;
        int exp_lat, cyc;
        model_op(is_d, we, code, addr, wdata, lat, exp, pre_err);
        exp_lat = pre_err ? 1 : (lat >= TB_TIMEOUT ? TB_TIMEOUT + 1 : lat + 2);
        if (is_d) dma_exp_q.push_back(exp); else cpu_exp_q.push_back(exp);
        resp_lat = lat;
        @(posedge clk); #1;
        if (is_d) begin
            dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_code = code; cpu_addr = addr; cpu_wdata = wdata;
            #1 check("cpu_stall", 64'(cpu_stall), 64'd1);
        end
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            seen = is_d ? dma_done : cpu_done;
        end
        cpu_req = 0; dma_req = 0;
        check(is_d ? "dma_latency" : "cpu_latency", 64'(cyc), 64'(exp_lat));
    endtask

    logic [3:0] codes [8] = '{CODE_LW, CODE_LH, CODE_LB, CODE_LHU, CODE_LBU, CODE_SW, CODE_SH, CODE_SB};

    initial begin
        logic [3:0]  code;
        logic        we;
        logic [31:0] addr;
        logic [32:0] exp;
        bit          pre_err;
        int          n, cyc, base, lat;

        reset_n = 0; cpu_req = 0; cpu_we = 0; cpu_code = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'(|{cpu_rdata, cpu_done, cpu_err, cpu_stall, dma_rdata, dma_done,
                                     dma_err, mem_en, mem_be, mem_addr, mem_wdata, dbg_state}), 64'd0);
        reset_n = 1;

        // lb of the top byte of 0x80FF1234 at 0x13, immediate rdy
        do_op(0, 1, CODE_SW, 32'h10, 32'h80FF_1234, 0);
        do_op(0, 0, CODE_LB, 32'h13, 32'h0, 0);

        // sh lane placement
        do_op(0, 1, CODE_SH, 32'h22, 32'h0000_ABCD, 0);
        check("sh_be",    64'(last_be), 64'h C);
        check("sh_wdata", 64'(last_wdata), 64'hABCD_ABCD);
        check("sh_addr",  64'(last_addr), 64'h20);

        // misaligned lw never reaches memory
        n = acc_count;
        do_op(0, 0, CODE_LW, 32'h06, 32'h0, 0);
        check("misalign_no_access", 64'(acc_count), 64'(n));

        // random CPU traffic
        for (int i = 0; i < 60; i++) begin
            code = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 7)];
            we = code[3];
            if ($urandom_range(0, 9) == 0) we = !we;
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
            lat = ($urandom_range(0, 11) == 0) ? NEVER : $urandom_range(0, 3);
            do_op(0, we, code, addr, $urandom, lat);
        end

        // random DMA traffic
        for (int i = 0; i < 30; i++) begin
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            lat = ($urandom_range(0, 11) == 0) ? NEVER : $urandom_range(0, 3);
            do_op(1, 1'($urandom_range(0, 1)), CODE_LW, addr, $urandom, lat);
        end

        // DMA timeout: strobe held TIMEOUT cycles
        do_op(1, 0, CODE_LW, 32'h40, 32'h0, NEVER);
        @(negedge clk); #1;
        check("timeout_en_cycles", 64'(last_en_len), 64'(TB_TIMEOUT));

        // both ports requesting continuously: CPU_BURST CPU grants then one DMA
        resp_lat = 0;
        for (int k = 0; k < 3 * (TB_BURST + 1); k++) begin
            if ((k % (TB_BURST + 1)) == TB_BURST) begin
                model_op(1, 0, CODE_LW, 32'h34, 32'h0, 0, exp, pre_err);
                dma_exp_q.push_back(exp);
            end else begin
                model_op(0, 0, CODE_LW, 32'h30, 32'h0, 0, exp, pre_err);
                cpu_exp_q.push_back(exp);
            end
        end
        base = order_log.size();
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_code = CODE_LW; cpu_addr = 32'h30;
        dma_req = 1; dma_we = 0; dma_addr = 32'h34;
        n = 0; cyc = 0;
        while (n < 3 * (TB_BURST + 1) && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (cpu_done || dma_done) n++;
        end
        cpu_req = 0; dma_req = 0;
        @(negedge clk); #1;
        check("arb_grants", 64'(n), 64'(3 * (TB_BURST + 1)));
        for (int k = 0; k < 3 * (TB_BURST + 1); k++) begin
            if (base + k < order_log.size())
                check($sformatf("arb_owner_%0d", k), 64'(order_log[base + k]),
                      64'((k % (TB_BURST + 1)) == TB_BURST));
        end

        // reset in the middle of an access
        resp_lat = NEVER;
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_code = CODE_LW; cpu_addr = 32'h40;
        repeat (3) @(posedge clk);
        #1;
        check("mid_access_en", 64'(mem_en), 64'd1);
        reset_n = 0;
        #1;
        check("async_reset_outputs", 64'(|{cpu_rdata, cpu_done, cpu_err, dma_rdata, dma_done,
                                          dma_err, mem_en, mem_be, mem_addr, mem_wdata, dbg_state}), 64'd0);
        cpu_req = 0;
        @(posedge clk); #1;
        reset_n = 1;
        do_op(0, 1, CODE_SW, 32'h00, 32'h0000_9A00, 0);
        do_op(0, 0, CODE_LBU, 32'h01, 32'h0, 0);

        repeat (4) @(posedge clk);
        #1;
        check("cpu_queue_drained", 64'(cpu_exp_q.size()), 64'd0);
        check("dma_queue_drained", 64'(dma_exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
